// File: rtl/sargantana_icache_refill_ctrl.sv
// sargantana_icache_refill_ctrl: I-cache miss refill and flush sequencer, sole writer of the tag/data memory
module sargantana_icache_refill_ctrl #(
  parameter int ICACHE_N_WAY = 4,
  parameter int SET_WIDHT = 256,
  parameter int TAG_WIDHT = 20,
  parameter int ADDR_WIDHT = 6,
  parameter int BEAT_WIDHT = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    miss_i,
  input  logic [ADDR_WIDHT-1:0]   miss_idx_i,
  input  logic [TAG_WIDHT-1:0]    miss_tag_i,
  input  logic [ICACHE_N_WAY-1:0] valid_bits_i,
  output logic                    miss_ready_o,
  input  logic                    flush_i,
  output logic                    l2_req_valid_o,
  input  logic                    l2_req_ready_i,
  output logic [ADDR_WIDHT-1:0]   l2_req_idx_o,
  output logic [TAG_WIDHT-1:0]    l2_req_tag_o,
  input  logic                    l2_rsp_valid_i,
  input  logic [BEAT_WIDHT-1:0]   l2_rsp_data_i,
  output logic [ICACHE_N_WAY-1:0] tag_req_o,
  output logic [ICACHE_N_WAY-1:0] data_req_o,
  output logic                    tag_we_o,
  output logic                    data_we_o,
  output logic                    flush_en_o,
  output logic                    valid_bit_o,
  output logic [SET_WIDHT-1:0]    cline_o,
  output logic [TAG_WIDHT-1:0]    tag_o,
  output logic [ADDR_WIDHT-1:0]   addr_o,
  output logic                    refill_done_o,
  output logic                    flush_done_o
);
  localparam int N_BEATS = SET_WIDHT / BEAT_WIDHT;
  localparam int BCW = N_BEATS > 1 ? $clog2(N_BEATS) : 1;
  localparam int WW = ICACHE_N_WAY > 1 ? $clog2(ICACHE_N_WAY) : 1;
  typedef enum logic [2:0] {IDLE, REQ, FILL, WRITE, FLUSH} state_t;
  state_t state, next;
  logic [BCW-1:0] beat_cnt;
  logic [WW-1:0] rr, victim, victim_q;
  logic flush_pend;
  logic [ADDR_WIDHT-1:0] set_cnt, idx_q;
  logic [TAG_WIDHT-1:0] tag_q;
  logic [SET_WIDHT-1:0] cline_q;
  logic accept, beat, last_beat, last_set;
  assign accept = state == IDLE && miss_i && !flush_i;
  assign beat = state == FILL && l2_rsp_valid_i;
  assign last_beat = beat_cnt == BCW'(N_BEATS - 1);
  assign last_set = &set_cnt;
  // descending scan so the lowest invalid way wins; round-robin only if all ways valid
  always_comb begin
    victim = rr;
    for (int w = ICACHE_N_WAY - 1; w >= 0; w--) if (!valid_bits_i[w]) victim = WW'(w);
  end
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = flush_i ? FLUSH : miss_i ? REQ : IDLE;
      REQ:     next = l2_req_ready_i ? FILL : REQ;
      FILL:    next = beat && last_beat ? WRITE : FILL;
      WRITE:   next = flush_pend || flush_i ? FLUSH : IDLE;
      FLUSH:   next = last_set ? IDLE : FLUSH;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      beat_cnt <= '0;
      rr <= '0;
      flush_pend <= 1'b0;
      set_cnt <= '0;
    end else begin
      state <= next;
      if (accept) begin
        idx_q <= miss_idx_i;
        tag_q <= miss_tag_i;
        victim_q <= victim;
        if (&valid_bits_i) rr <= rr == WW'(ICACHE_N_WAY - 1) ? '0 : rr + 1'b1;
      end
      if (beat) begin
        cline_q[beat_cnt * BEAT_WIDHT +: BEAT_WIDHT] <= l2_rsp_data_i;
        beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
      end
      if (next == FLUSH) flush_pend <= 1'b0;
      else if (flush_i && state inside {REQ, FILL, WRITE}) flush_pend <= 1'b1;
      if (state == FLUSH) set_cnt <= set_cnt + 1'b1;
    end
  end
  always_comb begin
    miss_ready_o = 1'b0;
    l2_req_valid_o = 1'b0;
    l2_req_idx_o = '0;
    l2_req_tag_o = '0;
    tag_req_o = '0;
    data_req_o = '0;
    tag_we_o = 1'b0;
    data_we_o = 1'b0;
    flush_en_o = 1'b0;
    valid_bit_o = 1'b0;
    cline_o = '0;
    tag_o = '0;
    addr_o = '0;
    refill_done_o = 1'b0;
    flush_done_o = 1'b0;
    if (!rst_i) begin
      miss_ready_o = state == IDLE && !flush_i;
      l2_req_valid_o = state == REQ;
      l2_req_idx_o = state == REQ ? idx_q : '0;
      l2_req_tag_o = state == REQ ? tag_q : '0;
      if (state == WRITE) begin
        tag_req_o = ICACHE_N_WAY'(1) << victim_q;
        data_req_o = ICACHE_N_WAY'(1) << victim_q;
        tag_we_o = 1'b1;
        data_we_o = 1'b1;
        valid_bit_o = 1'b1;
        cline_o = cline_q;
        tag_o = tag_q;
        addr_o = idx_q;
        refill_done_o = 1'b1;
      end
      if (state == FLUSH) begin
        tag_req_o = '1;
        tag_we_o = 1'b1;
        flush_en_o = 1'b1;
        addr_o = set_cnt;
        flush_done_o = last_set;
      end
    end
  end
endmodule

// File: tb/tb_sargantana_icache_refill_ctrl.sv
// tb_sargantana_icache_refill_ctrl: vector table, corner sequences and random misses against a victim/line model
module tb_sargantana_icache_refill_ctrl;
  localparam int NW = 4, SW = 256, TW = 20, AW = 6, BW = 64, NB = SW / BW;
  typedef logic [NB-1:0][BW-1:0] line_t;
  typedef struct {
    logic [AW-1:0] idx;
    logic [TW-1:0] tag;
    logic [NW-1:0] vb;
    logic [7:0]    b;
    int            way;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1;
  logic miss = 1'b0, flush = 1'b0, req_ready = 1'b0, rsp_valid = 1'b0;
  logic [AW-1:0] miss_idx = '0;
  logic [TW-1:0] miss_tag = '0;
  logic [NW-1:0] vbits = '0;
  logic [BW-1:0] rsp_data = '0;
  logic miss_ready, l2_req_valid, tag_we, data_we, flush_en, valid_bit, refill_done, flush_done;
  logic [AW-1:0] l2_req_idx, addr;
  logic [TW-1:0] l2_req_tag, tag_o;
  logic [NW-1:0] tag_req, data_req;
  logic [SW-1:0] cline;
  int checks = 0, errors = 0, rr = 0, rway;
  logic [NW-1:0] rvb;
  vec_t tbl [9];

  sargantana_icache_refill_ctrl dut (
    .clk_i(clk), .rst_i(rst), .miss_i(miss), .miss_idx_i(miss_idx), .miss_tag_i(miss_tag),
    .valid_bits_i(vbits), .miss_ready_o(miss_ready), .flush_i(flush), .l2_req_valid_o(l2_req_valid),
    .l2_req_ready_i(req_ready), .l2_req_idx_o(l2_req_idx), .l2_req_tag_o(l2_req_tag),
    .l2_rsp_valid_i(rsp_valid), .l2_rsp_data_i(rsp_data), .tag_req_o(tag_req), .data_req_o(data_req),
    .tag_we_o(tag_we), .data_we_o(data_we), .flush_en_o(flush_en), .valid_bit_o(valid_bit),
    .cline_o(cline), .tag_o(tag_o), .addr_o(addr), .refill_done_o(refill_done), .flush_done_o(flush_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // lowest invalid way, else the round-robin way which then advances
  function automatic int victim(input logic [NW-1:0] vb);
    int v;
    for (int w = 0; w < NW; w++) if (!vb[w]) return w;
    v = rr;
    rr = (rr + 1) % NW;
    return v;
  endfunction

  function automatic line_t mk_beats(input logic [7:0] b);
    line_t l;
    for (int i = 0; i < NB; i++) l[i] = {8{8'(b * (i + 1))}};
    return l;
  endfunction

  task automatic chk_rst_outs;
    chk("rst_outs", SW'({miss_ready, l2_req_valid, l2_req_idx, l2_req_tag, tag_req, data_req, tag_we, data_we,
                         flush_en, valid_bit, tag_o, addr, refill_done, flush_done}), SW'(0));
    chk("rst_line", cline, SW'(0));
  endtask

  task automatic flush_run;
    for (int a = 0; a < (1 << AW); a++) begin
      #1;
      chk("flush_cycle",
          SW'({flush_en, tag_we, valid_bit, data_we, data_req, tag_req, miss_ready, flush_done, addr}),
          SW'({1'b1, 1'b1, 1'b0, 1'b0, {NW{1'b0}}, {NW{1'b1}}, 1'b0, a == (1 << AW) - 1, AW'(a)}));
      step;
      flush = 1'($urandom);
    end
    flush = 1'b0;
    #1;
    chk("flush_end", SW'({miss_ready, flush_en, tag_we, l2_req_valid}), SW'(4'b1000));
  endtask

  task automatic do_miss(input logic [AW-1:0] idx, input logic [TW-1:0] tag, input logic [NW-1:0] vb,
                         input int way, input line_t beats, input int stall, input int gap,
                         input int flush_at, input int rst_at);
    miss = 1'b1; miss_idx = idx; miss_tag = tag; vbits = vb;
    #1;
    chk("miss_ready", SW'(miss_ready), SW'(1'b1));
    step;
    miss = 1'b0; miss_idx = AW'($urandom); miss_tag = TW'($urandom); vbits = NW'($urandom);
    for (int s = 0; s <= stall; s++) begin
      req_ready = s == stall; rsp_valid = 1'($urandom); rsp_data = {$urandom, $urandom};
      #1;
      chk("req_hold", SW'({l2_req_valid, l2_req_idx, l2_req_tag, tag_we, miss_ready}), SW'({1'b1, idx, tag, 2'b00}));
      step;
    end
    req_ready = 1'b0;
    for (int b = 0; b < NB; b++) begin
      for (int g = int'($urandom_range(gap, 0)); g > 0; g--) begin
        rsp_valid = 1'b0; rsp_data = {$urandom, $urandom}; flush = 1'b0;
        #1;
        chk("fill_quiet", SW'({tag_we, data_we, refill_done, l2_req_valid, miss_ready}), SW'(0));
        step;
      end
      if (b == rst_at) begin
        rst = 1'b1; flush = 1'b0; rsp_valid = 1'b1; rsp_data = {$urandom, $urandom};
        #1;
        chk_rst_outs();
        step;
        rst = 1'b0;
        rr = 0;
        for (int k = 0; k < 3; k++) begin
          #1;
          chk("post_rst", SW'({miss_ready, tag_we, data_we, refill_done, l2_req_valid, flush_en}), SW'(6'b100000));
          step;
        end
        rsp_valid = 1'b0;
        return;
      end
      rsp_valid = 1'b1; rsp_data = beats[b]; flush = b == flush_at;
      #1;
      chk("fill_quiet", SW'({tag_we, data_we, refill_done, l2_req_valid, miss_ready}), SW'(0));
      step;
    end
    rsp_valid = 1'b0; flush = 1'b0;
    #1;
    chk("wr_req", SW'({tag_req, data_req}), SW'({2{NW'(1) << way}}));
    chk("wr_ctl", SW'({tag_we, data_we, valid_bit, refill_done, flush_en, flush_done, miss_ready}), SW'(7'b1111000));
    chk("wr_addr_tag", SW'({addr, tag_o}), SW'({idx, tag}));
    chk("wr_line", cline, beats);
    step;
    if (flush_at >= 0) flush_run();
    else begin
      #1;
      chk("ready_after", SW'({miss_ready, tag_we, refill_done, flush_en}), SW'(4'b1000));
    end
  endtask

  initial begin
    tbl[0] = '{6'd5,  20'hABCDE, 4'b0000, 8'h11, 0};
    tbl[1] = '{6'd12, 20'h12345, 4'b1011, 8'h21, 2};
    tbl[2] = '{6'd0,  20'h00001, 4'b1111, 8'h31, 0};
    tbl[3] = '{6'd63, 20'hFFFFF, 4'b1111, 8'h41, 1};
    tbl[4] = '{6'd33, 20'h5A5A5, 4'b1111, 8'h51, 2};
    tbl[5] = '{6'd7,  20'h0F0F0, 4'b1111, 8'h61, 3};
    tbl[6] = '{6'd8,  20'h11111, 4'b1111, 8'h71, 0};
    tbl[7] = '{6'd9,  20'h22222, 4'b0110, 8'h81, 0};
    tbl[8] = '{6'd10, 20'h33333, 4'b1101, 8'h91, 1};
    repeat (3) step;
    #1;
    chk_rst_outs();
    rst = 1'b0;
    #1;
    chk("reset_ready", SW'({miss_ready, l2_req_valid, tag_we, flush_en}), SW'(4'b1000));
    step;
    for (int i = 0; i < 9; i++) begin
      void'(victim(tbl[i].vb));
      do_miss(tbl[i].idx, tbl[i].tag, tbl[i].vb, tbl[i].way, mk_beats(tbl[i].b), 0, 0, -1, -1);
    end
    flush = 1'b1; miss = 1'b1; miss_idx = 6'd3; vbits = '1;
    #1;
    chk("flush_blocks_miss", SW'(miss_ready), SW'(0));
    step;
    flush = 1'b0; miss = 1'b0;
    flush_run();
    rway = victim(4'b1111);
    do_miss(6'd20, 20'hCAFE0, 4'b1111, rway, mk_beats(8'hA1), 0, 0, 2, -1);
    rway = victim(4'b0000);
    do_miss(6'd40, 20'hBEEF1, 4'b0000, rway, mk_beats(8'h5B), 10, 0, -1, 2);
    rway = victim(4'b1111);
    do_miss(6'd41, 20'h0BEEF, 4'b1111, rway, mk_beats(8'hC3), 0, 0, -1, -1);
    for (int n = 0; n < 40; n++) begin
      rvb = ($urandom % 2) != 0 ? '1 : NW'($urandom);
      rway = victim(rvb);
      do_miss(AW'($urandom), TW'($urandom), rvb, rway,
              {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
              int'($urandom_range(3, 0)), int'($urandom_range(2, 0)),
              ($urandom % 6) == 0 ? int'($urandom_range(NB - 1, 0)) : -1,
              ($urandom % 10) == 0 ? int'($urandom_range(NB - 1, 0)) : -1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
